// File: rtl/zero_flag_unit.sv
// Registered status-flag unit for the calculator ALU: live flags, sticky
// accumulators since clear, and a saturating consecutive-zero counter.
//
// state  | meaning
// RUN    | results are accepted and flags update
// FROZEN | all state held, inputs ignored
module zero_flag_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_carry,
  input  logic             in_ovf,
  input  logic             clear,
  input  logic             freeze,
  output logic             out_valid,
  output logic             zero,
  output logic             neg,
  output logic             parity,
  output logic             carry,
  output logic             ovf,
  output logic             all_zero,
  output logic             any_carry,
  output logic             any_ovf,
  output logic [CNT_W-1:0] zero_run,
  output logic             zero_run_sat
);

  localparam logic [CNT_W-1:0] RUN_MAX = '1;

  typedef enum logic {RUN, FROZEN} state_t;
  state_t state_q, state_d;

  logic             accept;
  logic             in_zero;
  logic             all_zero_base, any_carry_base, any_ovf_base;
  logic [CNT_W-1:0] run_base;
  logic             all_zero_d, any_carry_d, any_ovf_d;
  logic [CNT_W-1:0] run_d;

  assign accept  = in_valid & ~freeze;
  assign in_zero = ~|in_data;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (freeze)  state_d = FROZEN;
      FROZEN:  if (!freeze) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Clear rebases the sticky state; a simultaneous result then accumulates
  // onto that fresh base, which makes clear-with-valid a restart.
  always_comb begin
    all_zero_base  = clear ? 1'b1 : all_zero;
    any_carry_base = clear ? 1'b0 : any_carry;
    any_ovf_base   = clear ? 1'b0 : any_ovf;
    run_base       = clear ? '0   : zero_run;
    all_zero_d     = all_zero_base;
    any_carry_d    = any_carry_base;
    any_ovf_d      = any_ovf_base;
    run_d          = run_base;
    if (in_valid) begin
      all_zero_d  = all_zero_base & in_zero;
      any_carry_d = any_carry_base | in_carry;
      any_ovf_d   = any_ovf_base | in_ovf;
      if (!in_zero)
        run_d = '0;
      else if (run_base != RUN_MAX)
        run_d = run_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      out_valid    <= 1'b0;
      zero         <= 1'b0;
      neg          <= 1'b0;
      parity       <= 1'b0;
      carry        <= 1'b0;
      ovf          <= 1'b0;
      all_zero     <= 1'b1;
      any_carry    <= 1'b0;
      any_ovf      <= 1'b0;
      zero_run     <= '0;
      zero_run_sat <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= accept;
      if (accept) begin
        zero   <= in_zero;
        neg    <= in_data[WIDTH-1];
        parity <= ^in_data;
        carry  <= in_carry;
        ovf    <= in_ovf;
      end
      if (!freeze && (clear || in_valid)) begin
        all_zero     <= all_zero_d;
        any_carry    <= any_carry_d;
        any_ovf      <= any_ovf_d;
        zero_run     <= run_d;
        zero_run_sat <= (run_d == RUN_MAX);
      end
    end
  end

endmodule

// File: tb/tb_zero_flag_unit.sv
// Bench for zero_flag_unit: directed test-plan steps followed by random
// traffic, every output compared each cycle against an integer model.
module tb_zero_flag_unit;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int RMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_carry = 1'b0, in_ovf = 1'b0, clear = 1'b0, freeze = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic out_valid, zero, neg, parity, carry, ovf, all_zero, any_carry, any_ovf, zero_run_sat;
  logic [CNT_W-1:0] zero_run;

  int tests = 0;
  int failed = 0;

  // reference model state
  int m_ov, m_zero, m_neg, m_par, m_carry, m_ovf, m_az, m_ac, m_ao, m_run;

  zero_flag_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_carry(in_carry), .in_ovf(in_ovf), .clear(clear), .freeze(freeze),
    .out_valid(out_valid), .zero(zero), .neg(neg), .parity(parity),
    .carry(carry), .ovf(ovf), .all_zero(all_zero), .any_carry(any_carry),
    .any_ovf(any_ovf), .zero_run(zero_run), .zero_run_sat(zero_run_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int r, input int v, input int d, input int c,
                            input int o, input int clr, input int frz);
    if (r == 0) begin
      m_ov = 0; m_zero = 0; m_neg = 0; m_par = 0; m_carry = 0; m_ovf = 0;
      m_az = 1; m_ac = 0; m_ao = 0; m_run = 0;
    end else if (frz != 0) begin
      m_ov = 0;
    end else begin
      if (clr != 0) begin
        m_az = 1; m_ac = 0; m_ao = 0; m_run = 0;
      end
      m_ov = v;
      if (v != 0) begin
        m_zero  = (d == 0) ? 1 : 0;
        m_neg   = (d >= (1 << (WIDTH - 1))) ? 1 : 0;
        m_par   = $countones(d) % 2;
        m_carry = c;
        m_ovf   = o;
        m_az    = m_az * m_zero;
        m_ac    = (m_ac + c > 0) ? 1 : 0;
        m_ao    = (m_ao + o > 0) ? 1 : 0;
        m_run   = (d == 0) ? ((m_run + 1 > RMAX) ? RMAX : m_run + 1) : 0;
      end
    end
  endtask

  task automatic step(input int r, input int v, input int d, input int c,
                      input int o, input int clr, input int frz);
    @(negedge clk);
    rst_n = 1'(r); in_valid = 1'(v); in_data = WIDTH'(d);
    in_carry = 1'(c); in_ovf = 1'(o); clear = 1'(clr); freeze = 1'(frz);
    @(posedge clk);
    model_edge(r, v, d, c, o, clr, frz);
    #1;
    check("out_valid", int'(out_valid), m_ov);
    check("zero", int'(zero), m_zero);
    check("neg", int'(neg), m_neg);
    check("parity", int'(parity), m_par);
    check("carry", int'(carry), m_carry);
    check("ovf", int'(ovf), m_ovf);
    check("all_zero", int'(all_zero), m_az);
    check("any_carry", int'(any_carry), m_ac);
    check("any_ovf", int'(any_ovf), m_ao);
    check("zero_run", int'(zero_run), m_run);
    check("zero_run_sat", int'(zero_run_sat), (m_run == RMAX) ? 1 : 0);
  endtask

  initial begin
    // reset for two edges, then a first zero result
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 8'h55, 1, 1, 0, 1);
    step(1, 1, 8'h00, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // saturation: 17 zeros total, then a non-zero
    for (int i = 0; i < 16; i++) step(1, 1, 8'h00, 0, 0, 0, 0);
    step(1, 1, 8'h01, 0, 0, 0, 0);
    // live flags
    step(1, 1, 8'h80, 1, 0, 0, 0);
    step(1, 1, 8'h7F, 0, 1, 0, 0);
    // freeze ignores valid and clear
    for (int i = 0; i < 3; i++) step(1, 1, 8'h00, 0, 0, 1, 1);
    step(1, 1, 8'h05, 1, 0, 0, 0);
    // clear with simultaneous valid restarts from that result
    step(1, 1, 8'h00, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    // reset mid-stream
    step(1, 1, 8'h00, 1, 0, 0, 0);
    step(0, 1, 8'h00, 1, 1, 0, 0);
    step(1, 1, 8'h00, 0, 0, 0, 0);
    step(1, 1, 8'h00, 0, 0, 0, 0);
    // random traffic, biased toward zero results to exercise the counter
    for (int i = 0; i < 400; i++) begin
      int r, v, d, c, o, clr, frz;
      r   = ($urandom_range(0, 49) == 0) ? 0 : 1;
      v   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      d   = ($urandom_range(0, 2) != 0) ? 0 : int'($urandom_range(0, 255));
      c   = ($urandom_range(0, 7) == 0) ? 1 : 0;
      o   = ($urandom_range(0, 7) == 0) ? 1 : 0;
      clr = ($urandom_range(0, 19) == 0) ? 1 : 0;
      frz = ($urandom_range(0, 9) == 0) ? 1 : 0;
      step(r, v, d, c, o, clr, frz);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
